// File: rtl/bcd7seg_pkg.sv
// Shared types and segment glyph constants for the BCD-to-seven-segment decoder.
// Segment vectors are ordered a..g with a in the MSB; 1 means the segment is lit.
package bcd7seg_pkg;

  typedef logic [6:0] seg7_t;
  typedef logic [3:0] bcd_t;

  // Decimal glyphs
  localparam seg7_t SEG_0 = 7'b1111110;
  localparam seg7_t SEG_1 = 7'b0110000;
  localparam seg7_t SEG_2 = 7'b1101101;
  localparam seg7_t SEG_3 = 7'b1111001;
  localparam seg7_t SEG_4 = 7'b0110011;
  localparam seg7_t SEG_5 = 7'b1011011;
  localparam seg7_t SEG_6 = 7'b1011111;
  localparam seg7_t SEG_7 = 7'b1110000;
  localparam seg7_t SEG_8 = 7'b1111111;
  localparam seg7_t SEG_9 = 7'b1111011;

  // Hex glyphs A, b, C, d, E, F
  localparam seg7_t SEG_HA = 7'b1110111;
  localparam seg7_t SEG_HB = 7'b0011111;
  localparam seg7_t SEG_HC = 7'b1001110;
  localparam seg7_t SEG_HD = 7'b0111101;
  localparam seg7_t SEG_HE = 7'b1001111;
  localparam seg7_t SEG_HF = 7'b1000111;

  localparam seg7_t SEG_ALL_ON  = 7'b1111111;
  localparam seg7_t SEG_ALL_OFF = 7'b0000000;

  // Map a logical pattern to the physical pad level.
  function automatic seg7_t seg_polarity(input seg7_t pattern, input bit active_low);
    return pattern ^ {7{active_low}};
  endfunction

endpackage

// File: rtl/bcd7seg_lut.sv
// Purely combinational 4-bit code to segment pattern lookup with an invalid flag.
// With HEX_MODE = 0, codes 10-15 blank the digit and raise invalid.
module bcd7seg_lut
  import bcd7seg_pkg::*;
#(
  parameter bit HEX_MODE = 1'b0
) (
  input  bcd_t  code,
  output seg7_t seg,
  output logic  invalid
);

  // Decode every one of the 16 codes so no X can reach the output register.
  always_comb begin
    seg     = SEG_ALL_OFF;
    invalid = 1'b0;
    unique case (code)
      4'd0:  seg = SEG_0;
      4'd1:  seg = SEG_1;
      4'd2:  seg = SEG_2;
      4'd3:  seg = SEG_3;
      4'd4:  seg = SEG_4;
      4'd5:  seg = SEG_5;
      4'd6:  seg = SEG_6;
      4'd7:  seg = SEG_7;
      4'd8:  seg = SEG_8;
      4'd9:  seg = SEG_9;
      4'd10: seg = HEX_MODE ? SEG_HA : SEG_ALL_OFF;
      4'd11: seg = HEX_MODE ? SEG_HB : SEG_ALL_OFF;
      4'd12: seg = HEX_MODE ? SEG_HC : SEG_ALL_OFF;
      4'd13: seg = HEX_MODE ? SEG_HD : SEG_ALL_OFF;
      4'd14: seg = HEX_MODE ? SEG_HE : SEG_ALL_OFF;
      4'd15: seg = HEX_MODE ? SEG_HF : SEG_ALL_OFF;
      default: seg = SEG_ALL_OFF;
    endcase
    if (code > 4'd9) begin
      invalid = !HEX_MODE;
    end
  end

endmodule

// File: rtl/bcd_to_7seg.sv
// Registered BCD-to-seven-segment decoder for a single display digit.
// Adds lamp-test/blank overrides and output polarity on top of the lookup, then
// registers everything so the pads see glitch-free segment levels.
module bcd_to_7seg
  import bcd7seg_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit HEX_MODE       = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  input  logic blank,
  input  logic lamp_test,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  output logic invalid
);

  localparam seg7_t SegResetLevel = seg_polarity(SEG_ALL_OFF, SEG_ACTIVE_LOW);

  bcd_t  code;
  seg7_t lut_seg;
  logic  lut_invalid;
  seg7_t pattern;
  seg7_t seg_d, seg_q;
  logic  invalid_q;

  assign code = {A, B, C, D};

  bcd7seg_lut #(
    .HEX_MODE (HEX_MODE)
  ) u_lut (
    .code    (code),
    .seg     (lut_seg),
    .invalid (lut_invalid)
  );

  // Override priority: lamp_test beats blank beats the decoded code.
  always_comb begin
    pattern = lut_seg;
    if (lamp_test) begin
      pattern = SEG_ALL_ON;
    end else if (blank) begin
      pattern = SEG_ALL_OFF;
    end
    seg_d = seg_polarity(pattern, SEG_ACTIVE_LOW);
  end

  // Output register; reset drives the off level for the chosen polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q     <= SegResetLevel;
      invalid_q <= 1'b0;
    end else begin
      seg_q     <= seg_d;
      invalid_q <= lut_invalid;
    end
  end

  assign a       = seg_q[6];
  assign b       = seg_q[5];
  assign c       = seg_q[4];
  assign d       = seg_q[3];
  assign e       = seg_q[2];
  assign f       = seg_q[1];
  assign g       = seg_q[0];
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_to_7seg.sv
// Directed bench for bcd_to_7seg: three instances cover the default build,
// HEX_MODE = 1 and SEG_ACTIVE_LOW = 1 from a shared set of inputs.
module tb_bcd_to_7seg;

  logic clk = 1'b0;
  logic rst_n;
  logic A, B, C, D;
  logic blank, lamp_test;

  logic a0, b0, c0, d0, e0, f0, g0, inv0;
  logic a1, b1, c1, d1, e1, f1, g1, inv1;
  logic a2, b2, c2, d2, e2, f2, g2, inv2;

  logic [6:0] seg0, seg1, seg2;
  assign seg0 = {a0, b0, c0, d0, e0, f0, g0};
  assign seg1 = {a1, b1, c1, d1, e1, f1, g1};
  assign seg2 = {a2, b2, c2, d2, e2, f2, g2};

  int pass_cnt  = 0;
  int check_cnt = 0;

  localparam logic [6:0] DEC_TAB [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };
  localparam logic [6:0] HEX_TAB [6] = '{
    7'b1110111, 7'b0011111, 7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  always #5 clk = ~clk;

  bcd_to_7seg #(.SEG_ACTIVE_LOW(1'b0), .HEX_MODE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D),
    .blank(blank), .lamp_test(lamp_test),
    .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0), .invalid(inv0)
  );

  bcd_to_7seg #(.SEG_ACTIVE_LOW(1'b0), .HEX_MODE(1'b1)) dut_hex (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D),
    .blank(blank), .lamp_test(lamp_test),
    .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1), .invalid(inv1)
  );

  bcd_to_7seg #(.SEG_ACTIVE_LOW(1'b1), .HEX_MODE(1'b0)) dut_al (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .C(C), .D(D),
    .blank(blank), .lamp_test(lamp_test),
    .a(a2), .b(b2), .c(c2), .d(d2), .e(e2), .f(f2), .g(g2), .invalid(inv2)
  );

  // Drive inputs on the falling edge, then wait past the next rising edge.
  task automatic step(input logic [3:0] code, input logic bl, input logic lt);
    @(negedge clk);
    {A, B, C, D} = code;
    blank        = bl;
    lamp_test    = lt;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {A, B, C, D} = 4'd8;
    blank = 1'b0;
    lamp_test = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_cnt++;
    if (seg0 !== 7'b0000000) $display("FAIL reset_seg got=%b want=0000000", seg0);
    else pass_cnt++;
    check_cnt++;
    if (inv0 !== 1'b0) $display("FAIL reset_invalid got=%b want=0", inv0);
    else pass_cnt++;
    check_cnt++;
    if (seg2 !== 7'b1111111) $display("FAIL reset_seg_al got=%b want=1111111", seg2);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check_cnt++;
    if (seg0 !== 7'b0000000) $display("FAIL reset_hold got=%b want=0000000", seg0);
    else pass_cnt++;
    @(posedge clk);
    #1;
    check_cnt++;
    if (seg0 !== 7'b1111111) $display("FAIL reset_release got=%b want=1111111", seg0);
    else pass_cnt++;
  endtask

  task automatic test_decimal();
    for (int i = 0; i < 10; i++) begin
      step(4'(i), 1'b0, 1'b0);
      check_cnt++;
      if (seg0 !== DEC_TAB[i] || inv0 !== 1'b0)
        $display("FAIL dec_%0d got=%b/%b want=%b/0", i, seg0, inv0, DEC_TAB[i]);
      else pass_cnt++;
      check_cnt++;
      if (seg1 !== DEC_TAB[i] || inv1 !== 1'b0)
        $display("FAIL dec_hex_%0d got=%b/%b want=%b/0", i, seg1, inv1, DEC_TAB[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_high_codes();
    for (int i = 10; i < 16; i++) begin
      step(4'(i), 1'b0, 1'b0);
      check_cnt++;
      if (seg0 !== 7'b0000000 || inv0 !== 1'b1)
        $display("FAIL bcd_code_%0d got=%b/%b want=0000000/1", i, seg0, inv0);
      else pass_cnt++;
      check_cnt++;
      if (seg1 !== HEX_TAB[i-10] || inv1 !== 1'b0)
        $display("FAIL hex_code_%0d got=%b/%b want=%b/0", i, seg1, inv1, HEX_TAB[i-10]);
      else pass_cnt++;
    end
    step(4'd3, 1'b0, 1'b0);
    check_cnt++;
    if (seg0 !== 7'b1111001 || inv0 !== 1'b0)
      $display("FAIL back_to_3 got=%b/%b want=1111001/0", seg0, inv0);
    else pass_cnt++;
  endtask

  task automatic test_overrides();
    step(4'd5, 1'b1, 1'b0);
    check_cnt++;
    if (seg0 !== 7'b0000000) $display("FAIL blank got=%b want=0000000", seg0);
    else pass_cnt++;
    step(4'd5, 1'b1, 1'b1);
    check_cnt++;
    if (seg0 !== 7'b1111111) $display("FAIL lamp_over_blank got=%b want=1111111", seg0);
    else pass_cnt++;
    step(4'd5, 1'b0, 1'b0);
    check_cnt++;
    if (seg0 !== 7'b1011011) $display("FAIL no_override got=%b want=1011011", seg0);
    else pass_cnt++;
    // invalid follows the code even while overrides are active
    step(4'd12, 1'b0, 1'b1);
    check_cnt++;
    if (seg0 !== 7'b1111111 || inv0 !== 1'b1)
      $display("FAIL lamp_invalid got=%b/%b want=1111111/1", seg0, inv0);
    else pass_cnt++;
    step(4'd14, 1'b1, 1'b0);
    check_cnt++;
    if (seg0 !== 7'b0000000 || inv0 !== 1'b1 || seg1 !== 7'b0000000 || inv1 !== 1'b0)
      $display("FAIL blank_invalid got=%b/%b %b/%b want=0000000/1 0000000/0",
               seg0, inv0, seg1, inv1);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // Output must track the code applied exactly one edge earlier.
    step(4'd2, 1'b0, 1'b0);
    @(negedge clk);
    {A, B, C, D} = 4'd9;
    check_cnt++;
    if (seg0 !== 7'b1101101) $display("FAIL latency_hold got=%b want=1101101", seg0);
    else pass_cnt++;
    @(posedge clk);
    #1;
    check_cnt++;
    if (seg0 !== 7'b1111011) $display("FAIL b2b_9 got=%b want=1111011", seg0);
    else pass_cnt++;
  endtask

  task automatic test_active_low();
    step(4'd1, 1'b0, 1'b0);
    check_cnt++;
    if (seg2 !== 7'b1001111) $display("FAIL al_code1 got=%b want=1001111", seg2);
    else pass_cnt++;
    step(4'd11, 1'b0, 1'b1);
    check_cnt++;
    if (seg2 !== 7'b0000000 || inv2 !== 1'b1)
      $display("FAIL al_lamp got=%b/%b want=0000000/1", seg2, inv2);
    else pass_cnt++;
    step(4'd1, 1'b0, 1'b0);
    // Mid-cycle reset must act before the next rising edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_cnt++;
    if (seg2 !== 7'b1111111 || inv2 !== 1'b0)
      $display("FAIL al_async_reset got=%b/%b want=1111111/0", seg2, inv2);
    else pass_cnt++;
    check_cnt++;
    if (seg0 !== 7'b0000000) $display("FAIL async_reset got=%b want=0000000", seg0);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_cnt++;
    if (seg2 !== 7'b1001111) $display("FAIL al_after_reset got=%b want=1001111", seg2);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_decimal();
    test_high_codes();
    test_overrides();
    test_back_to_back();
    test_active_low();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
